// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared UART types and constants (receiver and transmitter)
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY    = 3'd3,
`endif
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } uart_rx_state_t;

  // Value of the even-parity bit that accompanies a data byte.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_receiver_if.sv
// ============================================================================
// uart_receiver_if : serial line in, received byte and status pulses out
// Rev 1.0
// ============================================================================
`default_nettype none

interface uart_receiver_if;
  logic       rx;
  logic [7:0] received_byte;
  logic       received_ready;
  logic       framing_error;

  modport slave  (input  rx, output received_byte, received_ready, framing_error);
  modport master (output rx, input  received_byte, received_ready, framing_error);
endinterface

`default_nettype wire

// File: rtl/bit_synchronizer.sv
// ============================================================================
// bit_synchronizer : two-flop synchronizer with parameterized reset value
// Rev 1.0
// ============================================================================
`default_nettype none

module bit_synchronizer #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_receiver.sv
// ============================================================================
// uart_receiver : 8N1 UART receiver, mid-bit sampling, 1-cycle status pulses
// Optional even parity bit: define UART_RX_PARITY_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic          clk,
  input  logic          reset,
  uart_receiver_if.slave bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] c_half_last = CNT_W'(CLKS_PER_BIT / 2 - 1);

  uart_rx_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       byte_q, byte_d;
  logic             ready_q, ready_d;
  logic             ferr_q, ferr_d;
  logic             w_rx_s;
  logic             w_cnt_done;
  logic             w_parity_bad;

  bit_synchronizer #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (bus.rx),
    .q_o   (w_rx_s)
  );

  assign w_cnt_done = (cnt_q == c_bit_last);

`ifdef UART_RX_PARITY_EN
  logic par_err_q, par_err_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) par_err_q <= 1'b0;
    else        par_err_q <= par_err_d;
  end

  assign w_parity_bad = par_err_q;
`else
  assign w_parity_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      ready_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      ready_q   <= ready_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    ready_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
`endif

    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!w_rx_s) state_d = START;
      end

      // Re-check the start bit at its midpoint so short glitches are ignored.
      START: begin
        if (cnt_q == c_half_last) begin
          cnt_d   = '0;
          state_d = w_rx_s ? IDLE : DATA;
        end
      end

      DATA: begin
        if (w_cnt_done) begin
          cnt_d   = '0;
          shift_d = {w_rx_s, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (w_cnt_done) begin
          cnt_d     = '0;
          par_err_d = w_rx_s ^ even_parity(shift_q);
          state_d   = STOP;
        end
      end
`endif

      // A low stop bit means the line may be in a break; wait for it to rise.
      STOP: begin
        if (w_cnt_done) begin
          cnt_d = '0;
          if (w_rx_s && !w_parity_bad) begin
            byte_d  = shift_q;
            ready_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = w_rx_s ? IDLE : WAIT_HIGH;
          end
        end
      end

      WAIT_HIGH: begin
        cnt_d = '0;
        if (w_rx_s) state_d = IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.received_byte  = byte_q;
  assign bus.received_ready = ready_q;
  assign bus.framing_error  = ferr_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_receiver.sv
// ============================================================================
// tb_uart_receiver : directed frames with a scoreboard of expected pulses
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_receiver;
  import uart_pkg::*;

  localparam int CPB = 16;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic reset;

  uart_receiver_if bus ();

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         total    = 0;
  int         bad      = 0;
  int         rdy_cnt  = 0;
  int         fe_cnt   = 0;
  int         exp_rdy  = 0;
  int         exp_fe   = 0;
  int         snap;
  ev_t        exp_q[$];
  logic [7:0] last_good = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    bus.rx = b;
    wait_cycles(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d);
`endif
    drive_bit(stop_b);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_bad_parity(input logic [7:0] d);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(~(^d));
    drive_bit(1'b1);
  endtask
`endif

  task automatic push_ok(input logic [7:0] d);
    exp_q.push_back(ev_t'{is_err: 1'b0, data: d});
    last_good = d;
    exp_rdy++;
  endtask

  task automatic push_err();
    exp_q.push_back(ev_t'{is_err: 1'b1, data: last_good});
    exp_fe++;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 4 * CPB && exp_q.size() != 0; i++) @(negedge clk);
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.received_ready || bus.framing_error) begin
      ev_t e;
      chk("exclusive", 32'(bus.received_ready && bus.framing_error), 32'd0);
      if (bus.received_ready) rdy_cnt++;
      if (bus.framing_error)  fe_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 32'({bus.received_ready, bus.framing_error}), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_kind", 32'(bus.framing_error), 32'(e.is_err));
        chk("pulse_byte", 32'(bus.received_byte), 32'(e.data));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset  = 1'b0;
    bus.rx = 1'b1;
    wait_cycles(4);
    chk("reset_byte",  32'(bus.received_byte),  32'h00);
    chk("reset_ready", 32'(bus.received_ready), 32'd0);
    chk("reset_ferr",  32'(bus.framing_error),  32'd0);
    chk("reset_state", 32'(dut.state_q),        32'(IDLE));
    reset = 1'b1;
    wait_cycles(4);

    // Single good frame
    push_ok(8'h4C);
    send_frame(8'h4C, 1'b1);
    drain("frame_4c");
    chk("hold_4c", 32'(bus.received_byte), 32'h4C);
    chk("count_4c_rdy", 32'(rdy_cnt), 32'd1);
    chk("count_4c_fe",  32'(fe_cnt),  32'd0);

    // Back-to-back frames with no idle gap
    wait_cycles(2);
    push_ok(8'h95);
    push_ok(8'h00);
    send_frame(8'h95, 1'b1);
    send_frame(8'h00, 1'b1);
    drain("b2b");
    chk("count_b2b", 32'(rdy_cnt), 32'd3);

    // Short low glitch must be rejected
    wait_cycles(2);
    snap   = rdy_cnt + fe_cnt;
    bus.rx = 1'b0;
    wait_cycles(5);
    bus.rx = 1'b1;
    for (int n = 0; n < 8 && dut.state_q != IDLE; n++) @(negedge clk);
    chk("glitch_idle", 32'(dut.state_q), 32'(IDLE));
    wait_cycles(40);
    chk("glitch_no_pulse", 32'(rdy_cnt + fe_cnt), 32'(snap));

    // Bad stop bit followed by a long break, then a good frame
    push_err();
    send_frame(8'hA5, 1'b0);
    wait_cycles(40);
    bus.rx = 1'b1;
    wait_cycles(4);
    drain("ferr");
    chk("ferr_count",  32'(fe_cnt),  32'd1);
    chk("ferr_no_rdy", 32'(rdy_cnt), 32'd3);
    chk("ferr_hold",   32'(bus.received_byte), 32'h00);
    push_ok(8'h3C);
    send_frame(8'h3C, 1'b1);
    drain("after_break");
    chk("hold_3c", 32'(bus.received_byte), 32'h3C);

    // Reset asserted during bit 4 of a frame
    wait_cycles(2);
    snap = rdy_cnt + fe_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h11 >> i));
    bus.rx = 1'b1;
    wait_cycles(6);
    reset = 1'b0;
    wait_cycles(3);
    chk("midreset_byte",  32'(bus.received_byte),  32'h00);
    chk("midreset_ready", 32'(bus.received_ready), 32'd0);
    chk("midreset_ferr",  32'(bus.framing_error),  32'd0);
    bus.rx = 1'b1;
    reset  = 1'b1;
    last_good = 8'h00;
    wait_cycles(3 * CPB);
    chk("midreset_no_pulse", 32'(rdy_cnt + fe_cnt), 32'(snap));
    push_ok(8'h7E);
    send_frame(8'h7E, 1'b1);
    drain("after_reset");
    chk("hold_7e", 32'(bus.received_byte), 32'h7E);

`ifdef UART_RX_PARITY_EN
    wait_cycles(2);
    push_ok(8'h03);
    send_frame(8'h03, 1'b1);
    drain("parity_ok");
    push_err();
    send_bad_parity(8'h03);
    wait_cycles(4);
    drain("parity_bad");
    chk("parity_hold", 32'(bus.received_byte), 32'h03);
`endif

    wait_cycles(4);
    chk("total_ready", 32'(rdy_cnt), 32'(exp_rdy));
    chk("total_ferr",  32'(fe_cnt),  32'(exp_fe));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
